// File: rtl/hms_set_sequencer.sv
// Time-set sequencer for the 12-hr hms clock: arbitrates two 24-hr set requests, stops the clock,
// writes hrs/min/sec/am_pm through the load port and restores the original run state.
module hms_set_sequencer #(
    parameter int unsigned GAP         = 1,
    parameter int unsigned RUN_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [4:0] req0_hr,
    input  logic [5:0] req0_min,
    input  logic [5:0] req0_sec,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [4:0] req1_hr,
    input  logic [5:0] req1_min,
    input  logic [5:0] req1_sec,
    input  logic       run,
    input  logic       ui_ss,
    input  logic       ui_sel,
    input  logic       ui_inc,
    input  logic       ui_dec,
    output logic       ss,
    output logic       sel,
    output logic       inc,
    output logic       dec,
    output logic       load,
    output logic [2:0] addr,
    output logic [5:0] din,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       gnt
);

    localparam int unsigned CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned TW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_STOP, S_WAIT_STOP,
        S_LD_H, S_LD_M, S_LD_S, S_LD_AP,
        S_START, S_WAIT_RUN
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic          rr, rr_d;
    logic [4:0]    hr_q, hr_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          was_run, was_run_d;
    logic          ss_seq, ss_d;
    logic          load_d;
    logic [2:0]    addr_d;
    logic [5:0]    din_d;
    logic          busy_d, done_d, err_d, gnt_d;

    logic          idle;
    logic          pick1;
    logic          gap_done;
    logic [4:0]    hr_wrap;
    logic [4:0]    h12;
    logic          pm;
    logic [2:0]    ld_addr;
    logic [5:0]    ld_data;
    state_t        ld_next;

    // Round-robin: on a tie the requester that did not win last time goes first.
    assign idle       = (state == S_IDLE);
    assign pick1      = req1_valid & (~req0_valid | ~rr);
    assign req0_ready = idle & req0_valid & ~pick1;
    assign req1_ready = idle & pick1;

    // Panel buttons are locked out while a command owns the clock.
    assign ss  = (ui_ss & ~busy) | ss_seq;
    assign sel = ui_sel & ~busy;
    assign inc = ui_inc & ~busy;
    assign dec = ui_dec & ~busy;

    assign gap_done = (cnt == CW'(GAP));
    assign hr_wrap  = (hr_q >= 5'd12) ? (hr_q - 5'd12) : hr_q;
    assign h12      = (hr_wrap == 5'd0) ? 5'd12 : hr_wrap;
    assign pm       = (hr_q >= 5'd12);

    // Address, data and successor for the current load state.
    always_comb begin
        ld_addr = 3'd0;
        ld_data = 6'd0;
        ld_next = S_IDLE;
        case (state)
            S_LD_H:  begin ld_addr = 3'd3; ld_data = {1'b0, h12};   ld_next = S_LD_M;  end
            S_LD_M:  begin ld_addr = 3'd2; ld_data = min_q;         ld_next = S_LD_S;  end
            S_LD_S:  begin ld_addr = 3'd1; ld_data = sec_q;         ld_next = S_LD_AP; end
            S_LD_AP: begin ld_addr = 3'd4; ld_data = {5'b0, pm};    ld_next = S_START; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tcnt_d    = tcnt;
        rr_d      = rr;
        hr_d      = hr_q;
        min_d     = min_q;
        sec_d     = sec_q;
        was_run_d = was_run;
        ss_d      = 1'b0;
        load_d    = 1'b0;
        addr_d    = 3'd0;
        din_d     = 6'd0;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = 1'b0;
        gnt_d     = gnt;

        case (state)
            S_IDLE: begin
                if (req0_valid | req1_valid) begin
                    state_d   = S_CHECK;
                    busy_d    = 1'b1;
                    gnt_d     = pick1;
                    rr_d      = pick1;
                    hr_d      = pick1 ? req1_hr  : req0_hr;
                    min_d     = pick1 ? req1_min : req0_min;
                    sec_d     = pick1 ? req1_sec : req0_sec;
                    was_run_d = run;
                end
            end
            S_CHECK: begin
                cnt_d  = '0;
                tcnt_d = '0;
                if (hr_q > 5'd23 || min_q > 6'd59 || sec_q > 6'd59) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = was_run ? S_STOP : S_LD_H;
                end
            end
            S_STOP, S_START: begin
                ss_d = (cnt == '0);
                if (gap_done) begin
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = (state == S_STOP) ? S_WAIT_STOP : S_WAIT_RUN;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_WAIT_STOP, S_WAIT_RUN: begin
                if ((state == S_WAIT_STOP) ? ~run : run) begin
                    if (state == S_WAIT_STOP) begin
                        state_d = S_LD_H;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (tcnt == TW'(RUN_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            S_LD_H, S_LD_M, S_LD_S, S_LD_AP: begin
                if (cnt == '0) begin
                    load_d = 1'b1;
                    addr_d = ld_addr;
                    din_d  = ld_data;
                end
                if (gap_done) begin
                    cnt_d = '0;
                    if (state == S_LD_AP && !was_run) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = ld_next;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            tcnt    <= '0;
            rr      <= 1'b1;
            hr_q    <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            was_run <= 1'b0;
            ss_seq  <= 1'b0;
            load    <= 1'b0;
            addr    <= 3'd0;
            din     <= 6'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            gnt     <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            tcnt    <= tcnt_d;
            rr      <= rr_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            was_run <= was_run_d;
            ss_seq  <= ss_d;
            load    <= load_d;
            addr    <= addr_d;
            din     <= din_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            gnt     <= gnt_d;
        end
    end

endmodule
